// File: rtl/frame_proc_pkg.sv
// Shared definitions for the frame processing sequencer: FSM states, pixel
// operation encodings, pixel channel layout and the luma helper.
package frame_proc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_FS,
    RUN,
    DRAIN,
    ABORT_DRAIN,
    DONE
  } state_t;

  localparam logic [1:0] OP_PASS = 2'b00;
  localparam logic [1:0] OP_GRAY = 2'b01;
  localparam logic [1:0] OP_INV  = 2'b10;
  localparam logic [1:0] OP_THR  = 2'b11;

  // Pixel layout is {R,G,B}, four bits per channel.
  localparam int PIX_W = 12;
  localparam int CH_W  = 4;
  localparam int R_LSB = 8;
  localparam int G_LSB = 4;
  localparam int B_LSB = 0;

  // (R + 2G + B) >> 2; the 6-bit sum cannot overflow (max 60).
  function automatic logic [CH_W-1:0] luma(input logic [PIX_W-1:0] p);
    logic [5:0] sum_w;
    sum_w = {2'b00, p[R_LSB +: CH_W]}
          + {1'b0, p[G_LSB +: CH_W], 1'b0}
          + {2'b00, p[B_LSB +: CH_W]};
    return sum_w[5:2];
  endfunction

endpackage

// File: rtl/frame_proc_sequencer_pixel_op.sv
// pixel_op: combinational per-pixel transform (pass, gray, invert, threshold).
module pixel_op
  import frame_proc_pkg::*;
(
  input  logic [1:0]       op,
  input  logic [CH_W-1:0]  threshold,
  input  logic [PIX_W-1:0] pixel,
  output logic [PIX_W-1:0] result
);

  logic [CH_W-1:0] y;

  always_comb begin
    y      = luma(pixel);
    result = pixel;
    case (op)
      OP_PASS: result = pixel;
      OP_GRAY: result = {y, y, y};
      OP_INV:  result = ~pixel;
      OP_THR:  result = (y >= threshold) ? 12'hFFF : 12'h000;
      default: result = pixel;
    endcase
  end

endmodule

// File: rtl/frame_proc_sequencer.sv
// frame_proc_sequencer: streams a framebuffer through pixel_op via a fixed-latency
// read port and writes each result back. FRAME_PROC_CONTINUOUS_EN: repeat every frame until abort.
module frame_proc_sequencer
  import frame_proc_pkg::*;
#(
  parameter int ADDR_W    = 19,
  parameter int PIX_COUNT = 307200,
  parameter int RD_LAT    = 2
) (
  input  logic              CLK100MHZ,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              frame_sync,
  input  logic              stall,
  input  logic [1:0]        op_sel,
  input  logic [3:0]        threshold,
  input  logic [PIX_W-1:0]  rdata_alu,
  output logic [ADDR_W-1:0] raddr_alu,
  output logic [ADDR_W-1:0] waddr_alu,
  output logic [PIX_W-1:0]  wdata_alu,
  output logic              wen_alu,
  output logic              busy,
  output logic              done,
  output logic [7:0]        frame_cnt
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIX_COUNT - 1);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] ptr_reg, ptr_next;
  logic [1:0]        op_reg, op_next;
  logic [3:0]        thr_reg, thr_next;
  logic [7:0]        cnt_reg, cnt_next;
  logic              issue;
  logic              pipe_empty;
`ifdef FRAME_PROC_CONTINUOUS_EN
  logic              stop_reg, stop_next;
`endif

  logic              pipe_valid_reg [RD_LAT];
  logic [ADDR_W-1:0] pipe_addr_reg  [RD_LAT];
  logic [PIX_W-1:0]  op_result;
  logic              wen_reg;
  logic [ADDR_W-1:0] waddr_reg;
  logic [PIX_W-1:0]  wdata_reg;

  always_ff @(posedge CLK100MHZ) begin
    if (rst) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      op_reg    <= OP_PASS;
      thr_reg   <= '0;
      cnt_reg   <= '0;
`ifdef FRAME_PROC_CONTINUOUS_EN
      stop_reg  <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      op_reg    <= op_next;
      thr_reg   <= thr_next;
      cnt_reg   <= cnt_next;
`ifdef FRAME_PROC_CONTINUOUS_EN
      stop_reg  <= stop_next;
`endif
    end
  end

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    op_next    = op_reg;
    thr_next   = thr_reg;
    cnt_next   = cnt_reg;
    issue      = 1'b0;
`ifdef FRAME_PROC_CONTINUOUS_EN
    stop_next  = stop_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = WAIT_FS;
          op_next    = op_sel;
          thr_next   = threshold;
        end
      end
      WAIT_FS: begin
        if (abort) begin
          state_next = IDLE;
        end else if (frame_sync) begin
          state_next = RUN;
          ptr_next   = '0;
        end
      end
      RUN: begin
        // An abort suppresses the read of its own cycle.
        if (abort) begin
          state_next = ABORT_DRAIN;
        end else if (!stall) begin
          issue = 1'b1;
          if (ptr_reg == LAST_ADDR) begin
            state_next = DRAIN;
          end else begin
            ptr_next = ptr_reg + ADDR_W'(1);
          end
        end
      end
      DRAIN: begin
`ifdef FRAME_PROC_CONTINUOUS_EN
        if (abort) stop_next = 1'b1;
`endif
        if (pipe_empty) state_next = DONE;
      end
      ABORT_DRAIN: begin
        if (pipe_empty) state_next = IDLE;
      end
      DONE: begin
        cnt_next = cnt_reg + 8'd1;
`ifdef FRAME_PROC_CONTINUOUS_EN
        stop_next  = 1'b0;
        state_next = (abort || stop_reg) ? IDLE : WAIT_FS;
`else
        state_next = IDLE;
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    pipe_empty = 1'b1;
    for (int i = 0; i < RD_LAT; i++) begin
      if (pipe_valid_reg[i]) pipe_empty = 1'b0;
    end
  end

  // Read-latency tracker: advances every cycle, stalled cycles carry invalid slots.
  genvar gi;
  generate
    for (gi = 0; gi < RD_LAT; gi++) begin : g_pipe
      if (gi == 0) begin : g_head
        always_ff @(posedge CLK100MHZ) begin
          if (rst) begin
            pipe_valid_reg[gi] <= 1'b0;
            pipe_addr_reg[gi]  <= '0;
          end else begin
            pipe_valid_reg[gi] <= issue;
            pipe_addr_reg[gi]  <= ptr_reg;
          end
        end
      end else begin : g_tail
        always_ff @(posedge CLK100MHZ) begin
          if (rst) begin
            pipe_valid_reg[gi] <= 1'b0;
            pipe_addr_reg[gi]  <= '0;
          end else begin
            pipe_valid_reg[gi] <= pipe_valid_reg[gi-1];
            pipe_addr_reg[gi]  <= pipe_addr_reg[gi-1];
          end
        end
      end
    end
  endgenerate

  pixel_op u_pixel_op (
    .op        (op_reg),
    .threshold (thr_reg),
    .pixel     (rdata_alu),
    .result    (op_result)
  );

  always_ff @(posedge CLK100MHZ) begin
    if (rst) begin
      wen_reg   <= 1'b0;
      waddr_reg <= '0;
      wdata_reg <= '0;
    end else begin
      wen_reg <= pipe_valid_reg[RD_LAT-1];
      if (pipe_valid_reg[RD_LAT-1]) begin
        waddr_reg <= pipe_addr_reg[RD_LAT-1];
        wdata_reg <= op_result;
      end
    end
  end

  assign raddr_alu = ptr_reg;
  assign waddr_alu = waddr_reg;
  assign wdata_alu = wdata_reg;
  assign wen_alu   = wen_reg;
  assign busy      = (state_reg != IDLE);
  assign done      = (state_reg == DONE);
  assign frame_cnt = cnt_reg;

endmodule

// File: doc/frame_proc_sequencer.md
Name: frame_proc_sequencer

Overview:
- Sequences the processing port of mem_controller: raddr_alu, waddr_alu, wdata_alu, wen_alu and rdata_alu.
- On a start request it waits for the next frame boundary, then streams every pixel of the framebuffer through a fixed-latency read.
- Each returned pixel passes through a selectable per-pixel operation and is written back to the same address.
- Sits between top-level controls (SW/BTNS) and mem_controller in the CLK100MHZ domain.

Parameters:
- ADDR_W, 19, width of pixel addresses.
- PIX_COUNT, 307200, pixels per frame (640x480); last address is PIX_COUNT-1.
- RD_LAT, 2, cycles from raddr_alu presented to rdata_alu valid; must be at least 1.

Ports:
- CLK100MHZ  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- start  in  1  one-cycle request to process the next frame.
- abort  in  1  one-cycle request to stop issuing reads and drain.
- frame_sync  in  1  one-cycle frame-boundary pulse, already synchronised to CLK100MHZ.
- stall  in  1  port unavailable this cycle; no new read is issued.
- op_sel  in  2  00 pass, 01 gray, 10 invert, 11 threshold.
- threshold  in  4  threshold level for op 11.
- rdata_alu  in  12  pixel data {R[3:0],G[3:0],B[3:0]}.
- raddr_alu  out  ADDR_W  read address.
- waddr_alu  out  ADDR_W  write address.
- wdata_alu  out  12  write data.
- wen_alu  out  1  write enable.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a frame completes.
- frame_cnt  out  8  completed frames, wraps 255->0.

Behaviour:
- Reset: all outputs 0, state IDLE, read pointer 0, latency pipeline cleared. Reset mid-frame is immediate; nothing in flight is written.
- IDLE: start -> WAIT_FS. Latch op_sel and threshold on start; they stay fixed for the whole frame.
- WAIT_FS: frame_sync -> RUN, with the read pointer set to 0. If start and frame_sync arrive in the same cycle in IDLE, go to WAIT_FS only.
- RUN, read issue: each cycle with stall=0, drive raddr_alu=ptr, push {valid=1, ptr} into an RD_LAT-deep shift pipeline, then ptr++.
- RUN, stall: with stall=1, push an invalid entry and hold raddr_alu.
- RUN, exit: after issuing ptr=PIX_COUNT-1 -> DRAIN.
- Write-back: when a valid entry exits the pipeline, in that same cycle drive wen_alu=1, waddr_alu=the entry's address, wdata_alu=f(rdata_alu). Otherwise wen_alu=0.
- Write-back is registered: outputs are updated on the clock edge where data is valid. Read-to-write latency is RD_LAT+1 cycles.
- The pipeline keeps advancing regardless of stall or abort; the memory has fixed latency.
- DRAIN: once the pipeline is empty -> DONE.
- DONE: done=1 for one cycle, frame_cnt++, -> IDLE.
- abort in WAIT_FS: -> IDLE next cycle.
- abort in RUN: stop issuing reads, -> ABORT_DRAIN. When the pipeline is empty -> IDLE with no done pulse and frame_cnt unchanged. Writes already in flight still complete.
- Ignored inputs: start when not IDLE; frame_sync when not WAIT_FS; abort in IDLE or DONE.
- f(p), with p split into channels R, G, B:
  - pass: p.
  - gray: y = (R + 2G + B) >> 2, computed 6 bits wide and truncated to 4; output {y,y,y}.
  - invert: ~p.
  - threshold: y as in gray; output 12'hFFF if y >= threshold, else 12'h000.
- Throughput with no stall: PIX_COUNT reads in PIX_COUNT cycles.

Optional Feature:
- Macro: FRAME_PROC_CONTINUOUS_EN.
- Defined: DONE goes to WAIT_FS, not IDLE, so every subsequent frame is processed until abort. abort in WAIT_FS, RUN or DONE stops after any drain; an abort in DONE still lets that cycle's done pulse occur.
- Not defined: single-shot behaviour as above.

Decomposition:
- Package frame_proc_pkg holds:
  - the state enum: IDLE, WAIT_FS, RUN, DRAIN, ABORT_DRAIN, DONE;
  - op_sel encodings OP_PASS, OP_GRAY, OP_INV, OP_THR;
  - a pixel channel-slice constant.
- Sub-module pixel_op: purely combinational f(p); inputs op, threshold, pixel; output result. The sequencer instantiates it once.

Test Plan:
- PIX_COUNT=16, RD_LAT=2, op pass: start, then frame_sync -> reads 0..15 on consecutive cycles; 16 writes with waddr 0..15 and wdata equal to the memory model data; done pulses once; frame_cnt=1.
- op gray, rdata=12'h4C8 (R=4, G=12, B=8): y = (4+24+8)>>2 = 9 -> wdata=12'h999. Op threshold with threshold=9 -> 12'hFFF; threshold=10 -> 12'h000.
- stall high on cycles 3-5 of RUN -> raddr_alu holds; total 16 writes with no gaps in addresses; done occurs 3 cycles later than in the no-stall run.
- abort after 6 reads issued -> no further reads; exactly 6 writes (addresses 0..5); busy falls; no done; frame_cnt unchanged.
- rst asserted mid-RUN -> next cycle wen_alu=0, busy=0, state IDLE; a start issued afterwards processes normally from address 0.
- With FRAME_PROC_CONTINUOUS_EN defined: 3 frame_sync pulses -> 3 done pulses and frame_cnt=3. Without the macro: one done, then frame_sync pulses are ignored.
